// File: rtl/bus_datapath_pkg.sv
// rtl/bus_datapath_pkg.sv - shared opcodes, step encoding and bus-source encoding
// Purpose: common definitions for the single-bus datapath and its ALU.
// Contents: opcode localparams, step_e (sequencer steps), bus_sel_e (bus drivers),
//           opcode classification helpers.
package bus_datapath_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6
  } step_e;

  typedef enum logic [2:0] {
    BUS_NONE,
    BUS_RB,
    BUS_RC,
    BUS_PC,
    BUS_MDR,
    BUS_ZLO,
    BUS_ZHI
  } bus_sel_e;

  function automatic logic op_is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: op_is_legal = 1'b1;
      default:                                       op_is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_muldiv(input logic [4:0] op);
    op_is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_param.sv
// rtl/alu_param.sv - combinational ALU producing a double-width result
// Purpose: computes op(a, b); single-width ops return {0, result}, MUL returns the
//          full signed product, DIV returns {remainder, quotient}.
// Ports: i_op (5-bit opcode), i_a (Y operand, Rb), i_b (bus operand, Rc),
//        o_result (2*WIDTH, high half -> Zhigh, low half -> Zlow).
module alu_param
  import bus_datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]              w_amt;
  logic [SHW:0]                w_amt_inv;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [WIDTH-1:0]     w_sa;
  logic signed [WIDTH-1:0]     w_sb;
  logic signed [WIDTH-1:0]     w_quo;
  logic signed [WIDTH-1:0]     w_rem;
  logic                        w_div_zero;

  assign w_amt     = i_b[SHW-1:0];
  // Complementary shift for rotates; amount 0 gives a shift by WIDTH, which yields 0.
  assign w_amt_inv = (SHW+1)'(WIDTH) - {1'b0, w_amt};

  assign w_prod = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});

  // Divisor is forced to 1 on zero so the divider never sees x; the result is overridden.
  assign w_div_zero = (i_b == '0);
  assign w_sa  = $signed(i_a);
  assign w_sb  = $signed(w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : i_b);
  assign w_quo = w_sa / w_sb;
  assign w_rem = w_sa % w_sb;

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD: o_result[WIDTH-1:0] = i_a + i_b;
      OP_SUB: o_result[WIDTH-1:0] = i_a - i_b;
      OP_SHR: o_result[WIDTH-1:0] = i_a >> w_amt;
      OP_SHL: o_result[WIDTH-1:0] = i_a << w_amt;
      OP_ROR: o_result[WIDTH-1:0] = (i_a >> w_amt) | (i_a << w_amt_inv);
      OP_ROL: o_result[WIDTH-1:0] = (i_a << w_amt) | (i_a >> w_amt_inv);
      OP_AND: o_result[WIDTH-1:0] = i_a & i_b;
      OP_OR:  o_result[WIDTH-1:0] = i_a | i_b;
      OP_MUL: o_result = w_prod;
      OP_DIV: o_result = w_div_zero ? {i_a, {WIDTH{1'b1}}} : {w_rem, w_quo};
      OP_NEG: o_result[WIDTH-1:0] = -i_a;
      OP_NOT: o_result[WIDTH-1:0] = ~i_a;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// rtl/bus_datapath_seq.sv - single-bus datapath with internal T0..T6 sequencer
// Purpose: fetches instructions over a request/ack port and executes register ALU ops,
//          one bus source per step; MUL/DIV write LO then HI.
// Ports: clk, clr (sync active-high reset), run (keep fetching),
//        mem_addr/mem_rd/mem_ack/mem_rdata (instruction fetch port),
//        busy (not IDLE), err (sticky illegal opcode), pc,
//        dbg_sel/dbg_data (combinational register peek).
module bus_datapath_seq
  import bus_datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_rd,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] pc,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  step_e              r_state;
  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [WIDTH-1:0]   r_pc;
  logic [31:0]        r_ir;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_z;
  logic [WIDTH-1:0]   r_mar;
  logic [WIDTH-1:0]   r_mdr;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_err;
  logic               r_mem_rd;

  logic [4:0]         w_op;
  logic [3:0]         w_ra;
  logic [3:0]         w_rb;
  logic [3:0]         w_rc;
  logic               w_ra_ok;
  logic [WIDTH-1:0]   w_rb_val;
  logic [WIDTH-1:0]   w_rc_val;
  logic [WIDTH-1:0]   w_dbg;
  bus_sel_e           w_bus_sel;
  logic [WIDTH-1:0]   w_bus;
  logic [2*WIDTH-1:0] w_alu;
  step_e              w_end_state;
  logic               w_ir_unused;

  assign w_op = r_ir[31:27];
  assign w_ra = r_ir[26:23];
  assign w_rb = r_ir[22:19];
  assign w_rc = r_ir[18:15];
  assign w_ir_unused = &{1'b0, r_ir[14:0]};

  // Register indices beyond NREGS read as zero and are never written.
  assign w_ra_ok = ({1'b0, w_ra} < 5'(NREGS));

  always_comb begin
    w_rb_val = '0;
    w_rc_val = '0;
    w_dbg    = '0;
    if ({1'b0, w_rb} < 5'(NREGS))    w_rb_val = r_regs[w_rb[IDXW-1:0]];
    if ({1'b0, w_rc} < 5'(NREGS))    w_rc_val = r_regs[w_rc[IDXW-1:0]];
    if ({1'b0, dbg_sel} < 5'(NREGS)) w_dbg    = r_regs[dbg_sel[IDXW-1:0]];
  end

  // Bus driver decode: exactly one source per step.
  always_comb begin
    w_bus_sel = BUS_NONE;
    case (r_state)
      ST_T0:   w_bus_sel = BUS_PC;
      ST_T1:   w_bus_sel = BUS_ZLO;
      ST_T2:   w_bus_sel = BUS_MDR;
      ST_T3:   w_bus_sel = BUS_RB;
      ST_T4:   w_bus_sel = BUS_RC;
      ST_T5:   w_bus_sel = BUS_ZLO;
      ST_T6:   w_bus_sel = BUS_ZHI;
      default: w_bus_sel = BUS_NONE;
    endcase
  end

  always_comb begin
    w_bus = '0;
    case (w_bus_sel)
      BUS_RB:  w_bus = w_rb_val;
      BUS_RC:  w_bus = w_rc_val;
      BUS_PC:  w_bus = r_pc;
      BUS_MDR: w_bus = r_mdr;
      BUS_ZLO: w_bus = r_z[WIDTH-1:0];
      BUS_ZHI: w_bus = r_z[2*WIDTH-1:WIDTH];
      default: w_bus = '0;
    endcase
  end

  alu_param #(.WIDTH(WIDTH)) u_alu (
    .i_op     (w_op),
    .i_a      (r_y),
    .i_b      (w_bus),
    .o_result (w_alu)
  );

  // The END pseudo-step: chain straight into the next fetch while run is held.
  assign w_end_state = run ? ST_T0 : ST_IDLE;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_err    <= 1'b0;
      r_mem_rd <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) r_state <= ST_T0;
        end
        ST_T0: begin
          r_mar    <= w_bus;
          r_z      <= {{WIDTH{1'b0}}, w_bus + 1'b1};
          r_mem_rd <= 1'b1;
          r_state  <= ST_T1;
        end
        ST_T1: begin
          r_pc <= w_bus;
          if (mem_ack) begin
            r_mdr    <= mem_rdata;
            r_mem_rd <= 1'b0;
            r_state  <= ST_T2;
          end
        end
        ST_T2: begin
          r_ir    <= w_bus[31:0];
          r_state <= ST_T3;
        end
        ST_T3: begin
          r_y <= w_bus;
          if (!op_is_legal(w_op)) begin
            r_err   <= 1'b1;
            r_state <= w_end_state;
          end else begin
            r_state <= ST_T4;
          end
        end
        ST_T4: begin
          r_z     <= w_alu;
          r_state <= ST_T5;
        end
        ST_T5: begin
          if (op_is_muldiv(w_op)) begin
            r_lo    <= w_bus;
            r_state <= ST_T6;
          end else begin
            if (w_ra_ok) r_regs[w_ra[IDXW-1:0]] <= w_bus;
            r_state <= w_end_state;
          end
        end
        ST_T6: begin
          r_hi    <= w_bus;
          r_state <= w_end_state;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr = r_mar;
  assign mem_rd   = r_mem_rd;
  assign busy     = (r_state != ST_IDLE);
  assign err      = r_err;
  assign pc       = r_pc;
  assign dbg_data = w_dbg;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb/tb_bus_datapath_seq.sv - directed self-checking bench for bus_datapath_seq
module tb_bus_datapath_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH=32, NREGS=16
  logic        clr_a, run_a, mem_rd_a, mem_ack_a, busy_a, err_a, ack_force_a;
  logic [31:0] mem_addr_a, mem_rdata_a, pc_a, dbg_data_a;
  logic [3:0]  dbg_sel_a;
  // DUT B: WIDTH=64, NREGS=8
  logic        clr_b, run_b, mem_rd_b, mem_ack_b, busy_b, err_b;
  logic [63:0] mem_addr_b, mem_rdata_b, pc_b, dbg_data_b;
  logic [3:0]  dbg_sel_b;

  logic [31:0] mem_a [0:31];
  logic [31:0] mem_b [0:31];
  int          ack_delay;
  int          wcnt_a;
  int          n_cmp;
  int          n_bad;

  bus_datapath_seq dut_a (
    .clk(clk), .clr(clr_a), .run(run_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a),
    .mem_ack(mem_ack_a), .mem_rdata(mem_rdata_a), .busy(busy_a), .err(err_a),
    .pc(pc_a), .dbg_sel(dbg_sel_a), .dbg_data(dbg_data_a)
  );

  bus_datapath_seq #(.WIDTH(64), .NREGS(8)) dut_b (
    .clk(clk), .clr(clr_b), .run(run_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
    .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b), .busy(busy_b), .err(err_b),
    .pc(pc_b), .dbg_sel(dbg_sel_b), .dbg_data(dbg_data_b)
  );

  // Memory responders: A acks after ack_delay wait cycles (or when forced), B acks at once.
  always @(posedge clk) begin
    if (!mem_rd_a || mem_ack_a) wcnt_a <= 0;
    else                        wcnt_a <= wcnt_a + 1;
  end
  assign mem_ack_a   = (mem_rd_a && (wcnt_a >= ack_delay)) || ack_force_a;
  assign mem_rdata_a = mem_a[mem_addr_a[4:0]];
  assign mem_ack_b   = mem_rd_b;
  assign mem_rdata_b = {32'h0, mem_b[mem_addr_b[4:0]]};

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg_a(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    dbg_sel_a = idx;
    #1;
    check(tag, {32'h0, dbg_data_a}, {32'h0, exp});
  endtask

  task automatic chk_reg_b(input string tag, input logic [3:0] idx, input logic [63:0] exp);
    dbg_sel_b = idx;
    #1;
    check(tag, dbg_data_b, exp);
  endtask

  // One instruction on DUT A from IDLE: pulse run for one cycle, count busy cycles,
  // mem_rd cycles and whether mem_addr moved while mem_rd was high.
  task automatic step_a(output int cyc, output int rd_cyc, output bit moved);
    logic [31:0] addr0;
    bit          seen;
    cyc = 0; rd_cyc = 0; moved = 1'b0; seen = 1'b0; addr0 = '0;
    @(negedge clk); run_a = 1'b1;
    @(negedge clk); run_a = 1'b0;
    while (busy_a && cyc < 200) begin
      cyc++;
      if (mem_rd_a) begin
        rd_cyc++;
        if (!seen) begin addr0 = mem_addr_a; seen = 1'b1; end
        else if (mem_addr_a !== addr0) moved = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rdc;
    bit mv;
    n_cmp = 0; n_bad = 0;
    clr_a = 1'b1; run_a = 1'b0; ack_force_a = 1'b0; dbg_sel_a = 4'd1; ack_delay = 0;
    clr_b = 1'b1; run_b = 1'b0; dbg_sel_b = 4'd0;
    for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end

    mem_a[0]  = enc(5'b10001, 4'd1,  4'd0, 4'd0);  // NOT R1,R0     -> FFFFFFFF
    mem_a[1]  = enc(5'b10000, 4'd2,  4'd1, 4'd0);  // NEG R2,R1     -> 1
    mem_a[2]  = enc(5'b00011, 4'd3,  4'd2, 4'd2);  // ADD R3,R2,R2  -> 2
    mem_a[3]  = enc(5'b00011, 4'd4,  4'd3, 4'd3);  // ADD R4,R3,R3  -> 4
    mem_a[4]  = enc(5'b00011, 4'd5,  4'd4, 4'd2);  // ADD R5,R4,R2  -> 5
    mem_a[5]  = enc(5'b00011, 4'd6,  4'd5, 4'd3);  // ADD R6,R5,R3  -> 7
    mem_a[6]  = enc(5'b00100, 4'd7,  4'd3, 4'd5);  // SUB R7,R3,R5  -> -3
    mem_a[7]  = enc(5'b00110, 4'd8,  4'd2, 4'd5);  // SHL R8,R2,R5  -> 0x20
    mem_a[8]  = enc(5'b00100, 4'd8,  4'd8, 4'd3);  // SUB R8,R8,R3  -> 30
    mem_a[9]  = enc(5'b00110, 4'd8,  4'd2, 4'd8);  // SHL R8,R2,R8  -> 0x40000000
    mem_a[10] = enc(5'b00011, 4'd1,  4'd5, 4'd6);  // ADD R1,R5,R6  -> 12
    mem_a[11] = enc(5'b01110, 4'd9,  4'd7, 4'd8);  // MUL -3*2^30
    mem_a[12] = enc(5'b01111, 4'd9,  4'd6, 4'd0);  // DIV 7/0
    mem_a[13] = enc(5'b01111, 4'd9,  4'd6, 4'd7);  // DIV 7/-3
    mem_a[14] = enc(5'b11111, 4'd1,  4'd2, 4'd3);  // illegal
    mem_a[15] = enc(5'b01010, 4'd12, 4'd5, 4'd3);  // OR  R12 -> 7
    mem_a[16] = enc(5'b00111, 4'd11, 4'd2, 4'd2);  // ROR R11 -> 0x80000000
    mem_a[17] = enc(5'b00101, 4'd10, 4'd1, 4'd3);  // SHR R10 -> 3
    mem_a[18] = enc(5'b00100, 4'd13, 4'd0, 4'd2);  // SUB R13 -> FFFFFFFF
    mem_a[19] = enc(5'b01000, 4'd14, 4'd8, 4'd3);  // ROL R14 -> 1
    mem_a[20] = enc(5'b01001, 4'd15, 4'd6, 4'd5);  // AND R15 -> 5
    mem_a[21] = enc(5'b00011, 4'd1,  4'd1, 4'd1);  // ADD R1,R1,R1 (aborted by clr)

    mem_b[0] = enc(5'b10001, 4'd1, 4'd0, 4'd0);    // NOT R1,R0     -> all ones
    mem_b[1] = enc(5'b10000, 4'd2, 4'd1, 4'd0);    // NEG R2,R1     -> 1
    mem_b[2] = enc(5'b00011, 4'd3, 4'd2, 4'd2);    // ADD R3        -> 2
    mem_b[3] = enc(5'b00011, 4'd4, 4'd3, 4'd3);    // ADD R4        -> 4
    mem_b[4] = enc(5'b00011, 4'd5, 4'd4, 4'd2);    // ADD R5        -> 5
    mem_b[5] = enc(5'b00110, 4'd5, 4'd2, 4'd5);    // SHL R5,R2,R5  -> 32
    mem_b[6] = enc(5'b00011, 4'd5, 4'd5, 4'd2);    // ADD R5,R5,R2  -> 33
    mem_b[7] = enc(5'b10001, 4'd7, 4'd4, 4'd0);    // NOT R7,R4     -> ~4
    mem_b[8] = enc(5'b01000, 4'd6, 4'd7, 4'd5);    // ROL R6,R7,R5  -> ~(1<<35)
    mem_b[9] = enc(5'b01000, 4'd9, 4'd7, 4'd5);    // ROL R9 (dropped)

    repeat (3) @(negedge clk);
    check("rst_busy", {63'h0, busy_a}, 64'h0);
    check("rst_err", {63'h0, err_a}, 64'h0);
    check("rst_mem_rd", {63'h0, mem_rd_a}, 64'h0);
    check("rst_mem_addr", {32'h0, mem_addr_a}, 64'h0);
    check("rst_pc", {32'h0, pc_a}, 64'h0);
    check("rst_dbg", {32'h0, dbg_data_a}, 64'h0);

    // Continuous run of words 0..9 straight out of reset: 10 back-to-back instructions.
    clr_a = 1'b0; run_a = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      if (pc_a == 32'd10) run_a = 1'b0;
      if (busy_a) cyc++;
    end while (busy_a && cyc < 500);
    check("b2b_cycles", 64'(cyc), 64'd60);
    check("b2b_pc", {32'h0, pc_a}, 64'd10);
    chk_reg_a("r1_not", 4'd1, 32'hFFFF_FFFF);
    chk_reg_a("r2_neg", 4'd2, 32'h1);
    chk_reg_a("r5", 4'd5, 32'd5);
    chk_reg_a("r6", 4'd6, 32'd7);
    chk_reg_a("r7_sub", 4'd7, 32'hFFFF_FFFD);
    chk_reg_a("r8_shl", 4'd8, 32'h4000_0000);

    step_a(cyc, rdc, mv);
    check("add_cycles", 64'(cyc), 64'd6);
    check("add_rd_cycles", 64'(rdc), 64'd1);
    chk_reg_a("add_r1", 4'd1, 32'd12);
    check("add_pc", {32'h0, pc_a}, 64'd11);

    step_a(cyc, rdc, mv);
    check("mul_cycles", 64'(cyc), 64'd7);
    check("mul_hi", {32'h0, dut_a.r_hi}, 64'hFFFF_FFFF);
    check("mul_lo", {32'h0, dut_a.r_lo}, 64'h4000_0000);
    chk_reg_a("mul_r9", 4'd9, 32'h0);

    step_a(cyc, rdc, mv);
    check("div0_cycles", 64'(cyc), 64'd7);
    check("div0_lo", {32'h0, dut_a.r_lo}, 64'hFFFF_FFFF);
    check("div0_hi", {32'h0, dut_a.r_hi}, 64'd7);
    check("div0_err", {63'h0, err_a}, 64'h0);

    step_a(cyc, rdc, mv);
    check("div_lo", {32'h0, dut_a.r_lo}, 64'hFFFF_FFFE);
    check("div_hi", {32'h0, dut_a.r_hi}, 64'd1);

    step_a(cyc, rdc, mv);
    check("ill_cycles", 64'(cyc), 64'd4);
    check("ill_err", {63'h0, err_a}, 64'h1);
    chk_reg_a("ill_r1", 4'd1, 32'd12);
    check("ill_lo", {32'h0, dut_a.r_lo}, 64'hFFFF_FFFE);
    check("ill_pc", {32'h0, pc_a}, 64'd15);

    ack_delay = 3;
    step_a(cyc, rdc, mv);
    ack_delay = 0;
    check("wait_cycles", 64'(cyc), 64'd9);
    check("wait_rd_cycles", 64'(rdc), 64'd4);
    check("wait_addr_moved", {63'h0, mv}, 64'h0);
    chk_reg_a("or_r12", 4'd12, 32'd7);
    check("err_sticky", {63'h0, err_a}, 64'h1);

    step_a(cyc, rdc, mv);
    chk_reg_a("ror_r11", 4'd11, 32'h8000_0000);
    step_a(cyc, rdc, mv);
    chk_reg_a("shr_r10", 4'd10, 32'd3);
    step_a(cyc, rdc, mv);
    chk_reg_a("sub_wrap_r13", 4'd13, 32'hFFFF_FFFF);
    step_a(cyc, rdc, mv);
    chk_reg_a("rol_r14", 4'd14, 32'h1);
    step_a(cyc, rdc, mv);
    chk_reg_a("and_r15", 4'd15, 32'd5);
    check("and_pc", {32'h0, pc_a}, 64'd21);

    // clr while waiting in T1, with an acknowledge pending across the reset.
    ack_delay = 1000;
    @(negedge clk); run_a = 1'b1;
    @(negedge clk); run_a = 1'b0;
    cyc = 0;
    while (!mem_rd_a && cyc < 20) begin @(negedge clk); cyc++; end
    check("clr_reached_t1", {63'h0, mem_rd_a}, 64'h1);
    @(negedge clk);
    clr_a = 1'b1; ack_force_a = 1'b1;
    @(negedge clk);
    check("clr_busy", {63'h0, busy_a}, 64'h0);
    check("clr_mem_rd", {63'h0, mem_rd_a}, 64'h0);
    check("clr_pc", {32'h0, pc_a}, 64'h0);
    check("clr_err", {63'h0, err_a}, 64'h0);
    clr_a = 1'b0;
    repeat (2) @(negedge clk);
    check("late_ack_busy", {63'h0, busy_a}, 64'h0);
    check("late_ack_mem_rd", {63'h0, mem_rd_a}, 64'h0);
    check("clr_hi", {32'h0, dut_a.r_hi}, 64'h0);
    chk_reg_a("clr_r1", 4'd1, 32'h0);
    ack_force_a = 1'b0;
    ack_delay = 0;

    // DUT B: 64-bit, 8 registers, continuous run of words 0..9.
    clr_b = 1'b0; run_b = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      if (pc_b == 64'd10) run_b = 1'b0;
      if (busy_b) cyc++;
    end while (busy_b && cyc < 500);
    check("b_cycles", 64'(cyc), 64'd60);
    check("b_pc", pc_b, 64'd10);
    check("b_err", {63'h0, err_b}, 64'h0);
    chk_reg_b("b_r5_33", 4'd5, 64'd33);
    chk_reg_b("b_rol33", 4'd6, 64'hFFFF_FFF7_FFFF_FFFF);
    chk_reg_b("b_r1_no_alias", 4'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_reg_b("b_dbg9", 4'd9, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
